// File: rtl/ex_mdu.sv
// ex_mdu: execute-stage multiply/divide unit.
// Owns HI/LO, models mult/div latency with a busy counter, raises a hazard
// for ID-stage stalls and supplies mfhi/mflo data to the EX result mux.
// Optional macro MDU_MADD_EN adds SPECIAL2 madd/maddu/msub/msubu.
module ex_mdu #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Inst,
    input  logic        valid,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        start,
    output logic        busy,
    output logic        md_hazard,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] MD_out
);

    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] F_MFHI     = 6'b010000;
    localparam logic [5:0] F_MTHI     = 6'b010001;
    localparam logic [5:0] F_MFLO     = 6'b010010;
    localparam logic [5:0] F_MTLO     = 6'b010011;
    localparam logic [5:0] F_MULT     = 6'b011000;
    localparam logic [5:0] F_MULTU    = 6'b011001;
    localparam logic [5:0] F_DIV      = 6'b011010;
    localparam logic [5:0] F_DIVU     = 6'b011011;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             commit;

    logic [5:0] opcode, funct;
    logic       is_special;
    logic       dec_mult, dec_multu, dec_div, dec_divu;
    logic       dec_mfhi, dec_mthi, dec_mflo, dec_mtlo;
    logic       is_acc, acc_sub, acc_uns;
    logic       is_mul_class, is_div_class;

    logic [63:0] prod_s, prod_u;
    logic        a_neg, b_neg;
    logic [31:0] a_mag, b_mag, divisor, q_mag, r_mag, quot, rem;
    logic [63:0] res;
    logic        res_wr;

    logic [31:0] pend_hi, pend_lo;
    logic        pend_wr;

    logic unused_inst;

    assign opcode      = Inst[31:26];
    assign funct       = Inst[5:0];
    assign unused_inst = ^Inst[25:6];
    assign is_special  = (opcode == OP_SPECIAL);

    assign dec_mult  = is_special && (funct == F_MULT);
    assign dec_multu = is_special && (funct == F_MULTU);
    assign dec_div   = is_special && (funct == F_DIV);
    assign dec_divu  = is_special && (funct == F_DIVU);
    assign dec_mfhi  = is_special && (funct == F_MFHI);
    assign dec_mthi  = is_special && (funct == F_MTHI);
    assign dec_mflo  = is_special && (funct == F_MFLO);
    assign dec_mtlo  = is_special && (funct == F_MTLO);

`ifdef MDU_MADD_EN
    localparam logic [5:0] OP_SPECIAL2 = 6'b011100;
    // SPECIAL2 accumulate family: funct[2] selects subtract, funct[0] unsigned
    assign is_acc  = (opcode == OP_SPECIAL2) && (funct[5:3] == 3'b000) && (funct[1] == 1'b0);
    assign acc_sub = funct[2];
    assign acc_uns = funct[0];
`else
    assign is_acc  = 1'b0;
    assign acc_sub = 1'b0;
    assign acc_uns = 1'b0;
`endif

    assign is_mul_class = dec_mult | dec_multu | is_acc;
    assign is_div_class = dec_div | dec_divu;

    assign busy      = (state_q == ST_BUSY);
    assign start     = valid & (is_mul_class | is_div_class) & ~busy;
    assign md_hazard = start | busy;

    // Full-width products; sign-extended operands give the signed product mod 2^64
    assign prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
    assign prod_u = {32'd0, A} * {32'd0, B};

    // Signed divide via magnitudes: quotient truncates, remainder follows dividend
    assign a_neg   = dec_div & A[31];
    assign b_neg   = dec_div & B[31];
    assign a_mag   = a_neg ? (32'd0 - A) : A;
    assign b_mag   = b_neg ? (32'd0 - B) : B;
    assign divisor = (B == 32'd0) ? 32'd1 : b_mag;
    assign q_mag   = a_mag / divisor;
    assign r_mag   = a_mag % divisor;
    assign quot    = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
    assign rem     = a_neg ? (32'd0 - r_mag) : r_mag;

    // Select the result captured at issue; divide by zero leaves HI/LO untouched
    always_comb begin
        res    = prod_s;
        res_wr = 1'b1;
        if (dec_multu) begin
            res = prod_u;
        end else if (is_acc) begin
            if (acc_sub) begin
                res = {HI, LO} - (acc_uns ? prod_u : prod_s);
            end else begin
                res = {HI, LO} + (acc_uns ? prod_u : prod_s);
            end
        end else if (is_div_class) begin
            res    = {rem, quot};
            res_wr = (B != 32'd0);
        end
    end

    // Next-state: load latency on issue, count down, commit on the 1->0 step
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        commit  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_BUSY;
                    cnt_d   = is_div_class ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                end
            end
            ST_BUSY: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_IDLE;
                    commit  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State and latency counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Pending result captured on the issue edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_hi <= '0;
            pend_lo <= '0;
            pend_wr <= 1'b0;
        end else if (start) begin
            pend_hi <= res[63:32];
            pend_lo <= res[31:0];
            pend_wr <= res_wr;
        end
    end

    // HI/LO: completion write, or mthi/mtlo while idle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            HI <= '0;
            LO <= '0;
        end else if (commit) begin
            if (pend_wr) begin
                HI <= pend_hi;
                LO <= pend_lo;
            end
        end else if (valid && !busy) begin
            if (dec_mthi) HI <= A;
            if (dec_mtlo) LO <= A;
        end
    end

    // mfhi/mflo read path to the EX result mux
    always_comb begin
        MD_out = 32'd0;
        if (dec_mfhi) MD_out = HI;
        else if (dec_mflo) MD_out = LO;
    end

endmodule

// File: tb/tb_ex_mdu.sv
// tb_ex_mdu: directed bench for ex_mdu with a cycle-level reference model.
module tb_ex_mdu;

    localparam int unsigned NM = 5;
    localparam int unsigned ND = 10;

    localparam logic [31:0] I_NOP   = 32'h0000_0000;
    localparam logic [31:0] I_MFHI  = 32'h0000_0010;
    localparam logic [31:0] I_MTHI  = 32'h0000_0011;
    localparam logic [31:0] I_MFLO  = 32'h0000_0012;
    localparam logic [31:0] I_MTLO  = 32'h0000_0013;
    localparam logic [31:0] I_MULT  = 32'h0000_0018;
    localparam logic [31:0] I_MULTU = 32'h0000_0019;
    localparam logic [31:0] I_DIV   = 32'h0000_001A;
    localparam logic [31:0] I_DIVU  = 32'h0000_001B;
    localparam logic [31:0] I_MADD  = 32'h7000_0000;

    logic        clk, reset, valid;
    logic [31:0] inst, a, b;
    logic        start, busy, md_hazard;
    logic [31:0] hi, lo, md_out;

    int n_vec, n_err;

    ex_mdu #(.MULT_CYCLES(NM), .DIV_CYCLES(ND)) dut (
        .clk(clk), .reset(reset), .Inst(inst), .valid(valid), .A(a), .B(b),
        .start(start), .busy(busy), .md_hazard(md_hazard),
        .HI(hi), .LO(lo), .MD_out(md_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [31:0] m_hi, m_lo;
    logic        m_active;
    logic [64:0] m_res;
    int          cyc, m_end;

    function automatic bit m_is_md(input logic [31:0] i);
        logic [5:0] op, fn;
        op = i[31:26];
        fn = i[5:0];
        m_is_md = (op == 6'h00) && (fn >= 6'h18) && (fn <= 6'h1B);
`ifdef MDU_MADD_EN
        if (op == 6'h1C && (fn == 6'h00 || fn == 6'h01 || fn == 6'h04 || fn == 6'h05))
            m_is_md = 1'b1;
`endif
    endfunction

    function automatic int m_lat(input logic [31:0] i);
        m_lat = (i[31:26] == 6'h00 && (i[5:0] == 6'h1A || i[5:0] == 6'h1B)) ? ND : NM;
    endfunction

    // Returns {write_enable, new_hi, new_lo}
    function automatic logic [64:0] m_op(input logic [31:0] i, input logic [31:0] x,
                                         input logic [31:0] y, input logic [31:0] h,
                                         input logic [31:0] l);
        longint      sp, sq, sr;
        logic [63:0] up;
        logic [63:0] acc;
        sp   = longint'($signed(x)) * longint'($signed(y));
        up   = {32'd0, x} * {32'd0, y};
        acc  = {h, l};
        m_op = {1'b0, acc};
        if (i[31:26] == 6'h00) begin
            case (i[5:0])
                6'h18: m_op = {1'b1, 64'(sp)};
                6'h19: m_op = {1'b1, up};
                6'h1A: if (y != 32'd0) begin
                    sq   = longint'($signed(x)) / longint'($signed(y));
                    sr   = longint'($signed(x)) % longint'($signed(y));
                    m_op = {1'b1, 32'(sr), 32'(sq)};
                end
                6'h1B: if (y != 32'd0) m_op = {1'b1, x % y, x / y};
                default: ;
            endcase
        end
`ifdef MDU_MADD_EN
        else if (i[31:26] == 6'h1C) begin
            case (i[5:0])
                6'h00: m_op = {1'b1, acc + 64'(sp)};
                6'h01: m_op = {1'b1, acc + up};
                6'h04: m_op = {1'b1, acc - 64'(sp)};
                6'h05: m_op = {1'b1, acc - up};
                default: ;
            endcase
        end
`endif
    endfunction

    // Model state advance: completion at issue_edge+latency, else issue or moves
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_hi     = 32'd0;
            m_lo     = 32'd0;
            m_active = 1'b0;
            m_res    = '0;
            m_end    = 0;
        end else begin
            cyc = cyc + 1;
            if (m_active) begin
                if (cyc == m_end) begin
                    m_active = 1'b0;
                    if (m_res[64]) begin
                        m_hi = m_res[63:32];
                        m_lo = m_res[31:0];
                    end
                end
            end else if (valid) begin
                if (m_is_md(inst)) begin
                    m_active = 1'b1;
                    m_end    = cyc + m_lat(inst);
                    m_res    = m_op(inst, a, b, m_hi, m_lo);
                end else if (inst == I_MTHI) begin
                    m_hi = a;
                end else if (inst == I_MTLO) begin
                    m_lo = a;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec = n_vec + 1;
        if (act !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Per-cycle compare of all outputs against the model
    always @(negedge clk) begin
        logic        e_start;
        logic [31:0] e_md;
        e_start = valid & m_is_md(inst) & ~m_active;
        e_md    = (inst == I_MFHI) ? m_hi : (inst == I_MFLO) ? m_lo : 32'd0;
        chk("start", 32'(start), 32'(e_start));
        chk("busy", 32'(busy), 32'(m_active));
        chk("md_hazard", 32'(md_hazard), 32'(e_start | m_active));
        chk("HI", hi, m_hi);
        chk("LO", lo, m_lo);
        chk("MD_out", md_out, e_md);
    end

    // ---------------- stimulus ----------------
    task automatic set(input logic [31:0] i, input logic [31:0] x, input logic [31:0] y,
                       input logic v);
        inst  = i;
        a     = x;
        b     = y;
        valid = v;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        set(I_NOP, 32'd0, 32'd0, 1'b0);
        for (int k = 0; k < n; k++) step();
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        cyc   = 0;
        reset = 1'b1;
        set(I_NOP, 32'd0, 32'd0, 1'b0);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        step();
        step();
        reset = 1'b0;
        step();

        // mult -3 * 5
        set(I_MULT, 32'hFFFF_FFFD, 32'd5, 1'b1);
        #3 chk("mult_start", 32'(start), 32'd1);
        step();
        set(I_NOP, 32'd0, 32'd0, 1'b0);
        for (int k = 1; k <= 5; k++) begin
            #3 chk("mult_busy", 32'(busy), 32'd1);
            step();
        end
        #3 chk("mult_done_busy", 32'(busy), 32'd0);
        chk("mult_hi", hi, 32'hFFFF_FFFF);
        chk("mult_lo", lo, 32'hFFFF_FFF1);
        set(I_MFLO, 32'd0, 32'd0, 1'b1);
        #3 chk("mflo_out", md_out, 32'hFFFF_FFF1);
        step();

        // signed overflow divide, then unsigned divide
        set(I_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        step();
        idle(ND);
        #3 chk("div_ovf_lo", lo, 32'h8000_0000);
        chk("div_ovf_hi", hi, 32'd0);
        set(I_DIVU, 32'd7, 32'd2, 1'b1);
        step();
        idle(ND);
        #3 chk("divu_lo", lo, 32'd3);
        chk("divu_hi", hi, 32'd1);

        // signed divide with negative dividend: -7/2 -> q=-3, r=-1
        set(I_DIV, 32'hFFFF_FFF9, 32'd2, 1'b1);
        step();
        idle(ND);
        #3 chk("div_neg_lo", lo, 32'hFFFF_FFFD);
        chk("div_neg_hi", hi, 32'hFFFF_FFFF);

        // preload then divide by zero
        set(I_MTHI, 32'h11, 32'd0, 1'b1);
        step();
        set(I_MTLO, 32'h22, 32'd0, 1'b1);
        step();
        set(I_DIVU, 32'd7, 32'd0, 1'b1);
        step();
        set(I_NOP, 32'd0, 32'd0, 1'b0);
        for (int k = 1; k <= ND; k++) begin
            #3 chk("div0_busy", 32'(busy), 32'd1);
            step();
        end
        #3 chk("div0_idle", 32'(busy), 32'd0);
        chk("div0_hi", hi, 32'h11);
        chk("div0_lo", lo, 32'h22);
        set(I_MFHI, 32'd0, 32'd0, 1'b0);
        #3 chk("mfhi_out", md_out, 32'h11);
        step();

        // second mult while busy is ignored
        set(I_MULT, 32'd2, 32'd3, 1'b1);
        step();
        set(I_MULT, 32'd7, 32'd7, 1'b1);
        #3 chk("hz_start", 32'(start), 32'd0);
        chk("hz_hazard", 32'(md_hazard), 32'd1);
        step();
        idle(NM - 1);
        #3 chk("hz_hi", hi, 32'd0);
        chk("hz_lo", lo, 32'd6);
        chk("hz_idle", 32'(busy), 32'd0);

        // bubble carrying a mult encoding
        set(I_MULT, 32'd9, 32'd9, 1'b0);
        #3 chk("bub_start", 32'(start), 32'd0);
        chk("bub_hazard", 32'(md_hazard), 32'd0);
        step();
        #3 chk("bub_busy", 32'(busy), 32'd0);

        // accumulate encoding
        set(I_MTHI, 32'd0, 32'd0, 1'b1);
        step();
        set(I_MTLO, 32'hFFFF_FFFF, 32'd0, 1'b1);
        step();
        set(I_MADD, 32'd1, 32'd1, 1'b1);
        step();
        set(I_NOP, 32'd0, 32'd0, 1'b0);
`ifdef MDU_MADD_EN
        #3 chk("madd_busy", 32'(busy), 32'd1);
        idle(NM);
        #3 chk("madd_hi", hi, 32'd1);
        chk("madd_lo", lo, 32'd0);
`else
        #3 chk("madd_busy", 32'(busy), 32'd0);
        idle(NM);
        #3 chk("madd_hi", hi, 32'd0);
        chk("madd_lo", lo, 32'hFFFF_FFFF);
`endif

        // reset in the middle of a multu
        set(I_MTHI, 32'h55, 32'd0, 1'b1);
        step();
        set(I_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        step();
        idle(2);
        reset = 1'b1;
        #2;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_hi", hi, 32'd0);
        chk("mid_rst_lo", lo, 32'd0);
        reset = 1'b0;
        step();
        for (int k = 0; k < 4; k++) begin
            #3 chk("no_late_hi", hi, 32'd0);
            chk("no_late_lo", lo, 32'd0);
            chk("no_late_busy", 32'(busy), 32'd0);
            step();
        end

        // full multu after reset
        set(I_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        step();
        idle(NM);
        #3 chk("multu_hi", hi, 32'hFFFF_FFFE);
        chk("multu_lo", lo, 32'h0000_0001);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
